// File: rtl/ecc_pkg.sv
// Shared curve constants, point type and FSM encodings for the EC-ElGamal encryptor.
package ecc_pkg;

    localparam int DATAWIDTH = 8;

    // Curve y^2 = x^3 + A_COEF*x + b over GF(P_MOD), generator (GX, GY)
    localparam logic [DATAWIDTH-1:0] P_MOD  = DATAWIDTH'(17);
    localparam logic [DATAWIDTH-1:0] A_COEF = DATAWIDTH'(2);
    localparam logic [DATAWIDTH-1:0] GX     = DATAWIDTH'(5);
    localparam logic [DATAWIDTH-1:0] GY     = DATAWIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_G,
        ST_MUL_PK,
        ST_ADD_M,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DATAWIDTH-1:0] x;
        logic [DATAWIDTH-1:0] y;
        logic                 inf;
    } point_t;

    typedef enum logic {
        OP_ADD,
        OP_DBL
    } op_t;

    localparam point_t PT_INF = '{x: '0, y: '0, inf: 1'b1};
    localparam point_t PT_G   = '{x: GX, y: GY, inf: 1'b0};

endpackage

// File: rtl/ec_point_alu.sv
// Combinational affine point add/double over GF(P_MOD), with point-at-infinity handling.
module ec_point_alu
    import ecc_pkg::*;
(
    input  op_t    i_op,
    input  point_t i_p,
    input  point_t i_q,
    output point_t o_r
);

    localparam int W = DATAWIDTH;
    typedef logic [W-1:0] fe_t;

    function automatic fe_t f_add(input fe_t a, input fe_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
        return s[W-1:0];
    endfunction

    function automatic fe_t f_sub(input fe_t a, input fe_t b);
        logic [W:0] d;
        d = {1'b0, a} + {1'b0, P_MOD} - {1'b0, b};
        if (d >= {1'b0, P_MOD}) d = d - {1'b0, P_MOD};
        return d[W-1:0];
    endfunction

    function automatic fe_t f_mul(input fe_t a, input fe_t b);
        return fe_t'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, P_MOD});
    endfunction

    // Fermat inverse a^(P-2); a zero denominator never reaches a used result
    function automatic fe_t f_inv(input fe_t a);
        fe_t e;
        fe_t base;
        fe_t r;
        e    = P_MOD - fe_t'(2);
        base = a;
        r    = fe_t'(1);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = f_mul(r, base);
            base = f_mul(base, base);
        end
        return r;
    endfunction

    logic   w_dbl;
    logic   w_special;
    point_t w_sp;
    fe_t    w_num;
    fe_t    w_den;
    fe_t    w_x2;
    fe_t    w_lam;
    fe_t    w_x3;
    fe_t    w_y3;

    // Pick slope numerator/denominator (or a special-case result), then apply the shared chord/tangent formula
    always_comb begin
        w_dbl     = (i_op == OP_DBL) ||
                    (!i_p.inf && !i_q.inf && (i_p.x == i_q.x) && (i_p.y == i_q.y));
        w_special = 1'b1;
        w_sp      = PT_INF;
        w_num     = '0;
        w_den     = fe_t'(1);
        w_x2      = i_p.x;
        if (w_dbl) begin
            if (!i_p.inf && (i_p.y != '0)) begin
                w_special = 1'b0;
                w_num     = f_add(f_mul(fe_t'(3), f_mul(i_p.x, i_p.x)), A_COEF);
                w_den     = f_add(i_p.y, i_p.y);
            end
        end else if (i_p.inf) begin
            w_sp = i_q;
        end else if (i_q.inf) begin
            w_sp = i_p;
        end else if (i_p.x != i_q.x) begin
            w_special = 1'b0;
            w_num     = f_sub(i_q.y, i_p.y);
            w_den     = f_sub(i_q.x, i_p.x);
            w_x2      = i_q.x;
        end
        w_lam = f_mul(w_num, f_inv(w_den));
        w_x3  = f_sub(f_sub(f_mul(w_lam, w_lam), i_p.x), w_x2);
        w_y3  = f_sub(f_mul(w_lam, f_sub(i_p.x, w_x3)), i_p.y);
        if (w_special) begin
            o_r = w_sp;
        end else begin
            o_r.x   = w_x3;
            o_r.y   = w_y3;
            o_r.inf = 1'b0;
        end
    end

endmodule

// File: rtl/ecc_encrypt_seq.sv
// Sequential EC-ElGamal encryptor: C1 = k*G, C2 = M + k*PK using one shared point ALU.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; captures k, PK, M when start is seen
// ST_MUL_G  | constant-time double-and-add k*G, 2 cycles per key bit
// ST_MUL_PK | same schedule for k*PK
// ST_ADD_M  | C2 = M + k*PK
// ST_DONE   | publish outputs, pulse done, drop busy
module ecc_encrypt_seq
    import ecc_pkg::*;
#(
    parameter int DW = DATAWIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] k_in,
    input  logic [DW-1:0] PKx_in,
    input  logic [DW-1:0] PKy_in,
    input  logic [DW-1:0] Mx_in,
    input  logic [DW-1:0] My_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] C1x_out,
    output logic [DW-1:0] C1y_out,
    output logic [DW-1:0] C2x_out,
    output logic [DW-1:0] C2y_out
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    state_t        r_state;
    logic [BW-1:0] r_bit;
    logic          r_phase;   // 0: doubling cycle, 1: add cycle
    logic [DW-1:0] r_k;
    point_t        r_acc;
    point_t        r_pk;
    point_t        r_m;
    point_t        r_c1;
    point_t        r_kpk;
    point_t        r_c2;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [DW-1:0] r_c1x;
    logic [DW-1:0] r_c1y;
    logic [DW-1:0] r_c2x;
    logic [DW-1:0] r_c2y;

    op_t    w_op;
    point_t w_p;
    point_t w_q;
    point_t w_r;
    point_t w_acc_next;

    ec_point_alu u_alu (
        .i_op (w_op),
        .i_p  (w_p),
        .i_q  (w_q),
        .o_r  (w_r)
    );

    // Route the accumulator and current base into the shared ALU; keep the add result only for a 1 key bit
    always_comb begin
        w_op = r_phase ? OP_ADD : OP_DBL;
        w_p  = r_acc;
        w_q  = PT_G;
        case (r_state)
            ST_MUL_PK: w_q = r_pk;
            ST_ADD_M: begin
                w_op = OP_ADD;
                w_p  = r_m;
                w_q  = r_kpk;
            end
            default: ;
        endcase
        w_acc_next = r_k[r_bit] ? w_r : r_acc;
    end

    // Main sequencer: fixed 2*DW-cycle scalar multiplies, then message add and output publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_k     <= '0;
            r_acc   <= PT_INF;
            r_pk    <= '0;
            r_m     <= '0;
            r_c1    <= PT_INF;
            r_kpk   <= PT_INF;
            r_c2    <= PT_INF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_c1x   <= '0;
            r_c1y   <= '0;
            r_c2x   <= '0;
            r_c2y   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_k     <= k_in;
                        r_pk    <= '{x: PKx_in, y: PKy_in, inf: 1'b0};
                        r_m     <= '{x: Mx_in, y: My_in, inf: 1'b0};
                        r_acc   <= PT_INF;
                        r_bit   <= BW'(DW - 1);
                        r_phase <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MUL_G;
                    end
                end
                ST_MUL_G, ST_MUL_PK: begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_acc <= w_r;
                    end else if (r_bit == '0) begin
                        if (r_state == ST_MUL_G) begin
                            r_c1    <= w_acc_next;
                            r_state <= ST_MUL_PK;
                        end else begin
                            r_kpk   <= w_acc_next;
                            r_state <= ST_ADD_M;
                        end
                        r_acc <= PT_INF;
                        r_bit <= BW'(DW - 1);
                    end else begin
                        r_acc <= w_acc_next;
                        r_bit <= r_bit - BW'(1);
                    end
                end
                ST_ADD_M: begin
                    r_c2    <= w_r;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_err   <= r_c1.inf | r_c2.inf;
                    r_c1x   <= r_c1.inf ? '0 : r_c1.x;
                    r_c1y   <= r_c1.inf ? '0 : r_c1.y;
                    r_c2x   <= r_c2.inf ? '0 : r_c2.x;
                    r_c2y   <= r_c2.inf ? '0 : r_c2.y;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign C1x_out = r_c1x;
    assign C1y_out = r_c1y;
    assign C2x_out = r_c2x;
    assign C2y_out = r_c2y;

endmodule

// File: tb/tb_ecc_encrypt_seq.sv
// Scoreboard bench for ecc_encrypt_seq on y^2 = x^3+2x+2 mod 17, G=(5,1), order 19, PK = 7G.
module tb_ecc_encrypt_seq;

    localparam int DW      = 8;
    localparam int ORDER   = 19;
    localparam int SK      = 7;
    localparam int LATENCY = 34;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] k_in, PKx_in, PKy_in, Mx_in, My_in;
    logic          busy, done, err;
    logic [DW-1:0] C1x_out, C1y_out, C2x_out, C2y_out;

    ecc_encrypt_seq #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .k_in    (k_in),
        .PKx_in  (PKx_in),
        .PKy_in  (PKy_in),
        .Mx_in   (Mx_in),
        .My_in   (My_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .C1x_out (C1x_out),
        .C1y_out (C1y_out),
        .C2x_out (C2x_out),
        .C2y_out (C2y_out)
    );

    always #5 clk = ~clk;

    // Hand-computed multiples n*G, n = 0..18; index 0 is infinity, shown as (0,0)
    int tx[ORDER] = '{0, 5, 6, 10, 3, 9, 16, 0, 13, 7, 7, 13, 0, 16, 9, 3, 10, 6, 5};
    int ty[ORDER] = '{0, 1, 3, 6, 1, 16, 13, 6, 7, 6, 11, 10, 11, 4, 1, 16, 11, 14, 16};

    typedef struct {
        int c1x;
        int c1y;
        int c2x;
        int c2y;
        int err;
        int t0;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = q_exp.pop_front();
                chk("c1x", int'(C1x_out), mon_e.c1x);
                chk("c1y", int'(C1y_out), mon_e.c1y);
                chk("c2x", int'(C2x_out), mon_e.c2x);
                chk("c2y", int'(C2y_out), mon_e.c2y);
                chk("err", int'(err), mon_e.err);
                chk("latency", cyc - mon_e.t0, LATENCY);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Drive one request from a negedge and push its expected ciphertext (message M = m*G)
    task automatic issue(input int k, input int m);
        exp_t e;
        int   i1;
        int   i2;
        i1      = k % ORDER;
        i2      = (m + SK * k) % ORDER;
        e.c1x   = tx[i1];
        e.c1y   = ty[i1];
        e.c2x   = tx[i2];
        e.c2y   = ty[i2];
        e.err   = (i1 == 0 || i2 == 0) ? 1 : 0;
        e.t0    = cyc + 1;
        k_in    = DW'(k);
        PKx_in  = DW'(tx[SK]);
        PKy_in  = DW'(ty[SK]);
        Mx_in   = DW'(tx[m]);
        My_in   = DW'(ty[m]);
        start   = 1'b1;
        q_exp.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({"done_seen_", name}, int'(done), 1);
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        k_in   = '0;
        PKx_in = '0;
        PKy_in = '0;
        Mx_in  = '0;
        My_in  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_c1x", int'(C1x_out), 0);
        chk("rst_c2y", int'(C2y_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3, 1);
        wait_done("k3_mG");

        // Back-to-back sweep: start driven in the same cycle done is high
        for (int k = 1; k <= 18; k++) begin
            issue(k, 2);
            wait_done("k_sweep");
        end

        issue(0, 1);
        wait_done("k0");
        issue(19, 1);
        wait_done("k19");
        issue(255, 5);
        wait_done("k255");
        issue(1, 12);
        wait_done("c2_inf");

        // Re-pulsed start and changing inputs mid-run must be ignored
        issue(6, 4);
        ok = 1;
        for (int c = 2; c < 60 && !done; c++) begin
            if (!busy) ok = 0;
            start = (c == 5 || c == 20);
            if (c == 5 || c == 20) begin
                k_in  = DW'(c * 7);
                Mx_in = DW'(9);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_held", ok, 1);
        wait_done("ignored_restart");
        repeat (40) @(negedge clk);

        // Reset mid-run: abort, clear outputs, no done; then a clean run
        issue(5, 3);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        q_exp.delete();
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_c1x", int'(C1x_out), 0);
        chk("abort_c2x", int'(C2x_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        issue(5, 3);
        wait_done("after_reset");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ecc_encrypt_seq.md
Name: ecc_encrypt_seq

Overview:
- Sequential EC-ElGamal encryptor: C1 = k·G, C2 = M + k·PK over the curve and prime field fixed in parameters.vh.
- Counterpart of the combinational decryption block; its (C1, C2) output feeds that block directly.
- Uses one shared point add/double unit driven by a fixed-schedule double-and-add FSM.
- Runs in constant time: the add step is always executed and the result is discarded when the key bit is 0.

Parameters:
- DW, `DATAWIDTH: field element and scalar width.
- Curve constants P_MOD, A_COEF, GX, GY come from the shared package, not parameters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- k_in  in  DW  ephemeral scalar
- PKx_in, PKy_in  in  DW each  recipient public key
- Mx_in, My_in  in  DW each  message point
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse, outputs valid
- err  out  1  valid with done; C1 or C2 is the point at infinity
- C1x_out, C1y_out, C2x_out, C2y_out  out  DW each  ciphertext; held until next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, err and all C* outputs = 0.
  - Internal accumulator = infinity.
- Input capture: in IDLE with start=1, k_in, PK and M are registered. Later input changes are ignored.
- States: IDLE -> MUL_G -> MUL_PK -> ADD_M -> DONE -> IDLE.
- MUL_G:
  - Bit index i runs DW-1 down to 0, MSB-first; accumulator starts at infinity.
  - Each bit takes 2 cycles: DBL (acc = 2·acc), then ADD (tmp = acc + G; acc = k[i] ? tmp : acc).
  - After 2·DW cycles, acc is latched into the C1 register; acc is reset to infinity.
- MUL_PK: same schedule with base PK, 2·DW cycles; result is latched as kPK.
- ADD_M: 1 cycle, C2 = M + kPK.
- DONE (1 cycle):
  - done=1, busy=0.
  - C* outputs update.
  - err = C1 at infinity OR C2 at infinity; the outputs of an infinity point are forced to 0.
- Latency: start sampled at edge t gives done high during cycle t+4·DW+2. With DW=8 this is 34 cycles.
- start while busy or in DONE: ignored, not queued.
- Back-to-back: start may be asserted in the cycle after done.
- Point arithmetic rules (all results reduced mod P_MOD, values in [0, P_MOD-1]):
  - O+Q = Q, Q+O = Q.
  - Q + (−Q) = O.
  - 2·O = O; 2·Q with y=0 gives O.
  - Q+Q in ADD is routed to the doubling formula.
- k_in=0 or k ≡ 0 mod the group order: C1=O, so err=1.
- Reset mid-operation: abort immediately, all outputs are 0, and no done is produced.

Decomposition:
- Package ecc_pkg holds:
  - P_MOD, A_COEF, GX, GY.
  - State encoding.
  - Point struct {x, y, inf}.
  - Op enum {OP_ADD, OP_DBL}.
- Sub-module ec_point_alu: combinational.
  - Inputs: op, P, Q with inf flags.
  - Output: R with inf flag.
  - Contains modular add/sub/mul and inverse via Fermat exponentiation or extended Euclid.
- The FSM, bit counter and registers live in ecc_encrypt_seq. This is about 150–250 lines excluding the ALU.

Test Plan:
Bench curve: y² = x³+2x+2 mod 17, G=(5,1), order 19, DW=8. Secret key sk=7 gives PK = 7G = (0,6).
1. k=3, M=G=(5,1) -> done at cycle 34; C1=(10,6), C2=(10,6), err=0.
2. k=3, M=(5,1), ciphertext from scenario 1 fed to the decryption block with sk=7 -> recovers (5,1). Repeat for k=1..18 with M=2G=(6,3).
3. k=0 -> done at 34, err=1, C1=(0,0). k=19 -> same.
4. k=1, M=(0,11) (= −PK) -> C1=(5,1), C2=O, so err=1 and C2=(0,0).
5. start re-pulsed at cycles 5 and 20, and k_in changed mid-run -> single done at 34 with results from the original inputs; busy held high throughout.
6. rst_n low at cycle 15 for 1 cycle -> outputs and busy 0, no done. A new start afterwards gives correct results with full 34-cycle latency.
